medfilt_win_ctrl: RTL and testbench

- Raster-scan sequencer for the 3x3 median filter datapath.
- Accepts the pixel stream and drives the two line buffers' address and write-enable.
- Issues per-column "sort" strobes and top, bottom, left and right border-replicate controls.
- Generates the bottom-border flush row itself, and delays valid, start-of-frame and end-of-line by the fixed latency of the non-stallable sort pipeline.

---
 rtl/medfilt_pkg.sv | 24 ++
 rtl/medfilt_delay_line.sv | 32 +++
 rtl/medfilt_win_ctrl.sv | 165 ++++++++++++++++
 tb/tb_medfilt_win_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/medfilt_pkg.sv
// rtl/medfilt_pkg.sv - shared types and defaults for the 3x3 median filter window controller
package medfilt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_W      = 640;
    localparam int DEF_IMG_H      = 480;
    localparam int DEF_PIPE_LAT   = 9;

    // Counter width for a count of n positions; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_X_W = cnt_width(DEF_IMG_W);
    localparam int DEF_Y_W = cnt_width(DEF_IMG_H);

endpackage

// File: rtl/medfilt_delay_line.sv
// rtl/medfilt_delay_line.sv - reset-cleared fixed-depth shift register for strobe alignment
module medfilt_delay_line
    import medfilt_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = DEF_PIPE_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift the strobes one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/medfilt_win_ctrl.sv
// rtl/medfilt_win_ctrl.sv - raster sequencer for the 3x3 median window (optional MEDFILT_WIN_CTRL_ERR_EN)
module medfilt_win_ctrl
    import medfilt_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_sof,
    output logic [$clog2(IMG_W)-1:0] lb_addr,
    output logic                     lb_wr_en,
    output logic [DATA_WIDTH-1:0]    lb_wdata,
    output logic                     col_valid,
    output logic                     top_rep,
    output logic                     bot_rep,
    output logic                     left_rep,
    output logic                     right_rep,
    output logic                     out_valid,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     busy
`ifdef MEDFILT_WIN_CTRL_ERR_EN
    ,
    output logic                     err_sof,
    output logic [15:0]              frame_cnt
`endif
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          win_active;
    logic [2:0]    strobe_in;
    logic [2:0]    strobe_out;

    // Position tracking: prime row 0, run rows 1..H-1, then self-generated bottom flush row
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_sof) begin
                        state <= PRIME;
                        x     <= XW'(1);
                    end
                end
                PRIME: begin
                    if (in_valid) begin
                        if (x == X_LAST) begin
                            x     <= '0;
                            y     <= Y_ONE;
                            state <= RUN;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                state <= FLUSH;
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (x == X_LAST) begin
                        x     <= '0;
                        y     <= '0;
                        state <= IDLE;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line-buffer write and column strobe; flush keeps the shift cadence without input
    always_comb begin
        lb_wr_en  = 1'b0;
        col_valid = 1'b0;
        unique case (state)
            IDLE:    lb_wr_en = in_valid && in_sof;
            PRIME:   lb_wr_en = in_valid;
            RUN: begin
                lb_wr_en  = in_valid;
                col_valid = in_valid;
            end
            FLUSH: begin
                lb_wr_en  = 1'b1;
                col_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign win_active = (state == RUN) || (state == FLUSH);
    assign in_ready   = (state != FLUSH);
    assign busy       = (state != IDLE);
    assign lb_addr    = x;
    assign lb_wdata   = in_data;
    assign top_rep    = (state == RUN) && (y == Y_ONE);
    assign bot_rep    = (state == FLUSH);
    assign left_rep   = win_active && (x == '0);
    assign right_rep  = win_active && (x == X_LAST);

    assign strobe_in = {col_valid, col_valid && top_rep && left_rep, col_valid && right_rep};

    medfilt_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (strobe_in),
        .dout (strobe_out)
    );

    assign out_valid = strobe_out[2];
    assign out_sof   = strobe_out[1];
    assign out_eol   = strobe_out[0];

`ifdef MEDFILT_WIN_CTRL_ERR_EN
    // Sticky flag for a start-of-frame landing mid-frame; count frames completed by flush
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sof   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (in_valid && in_sof && (state == PRIME || state == RUN) && (x != '0 || y != '0)) begin
                err_sof <= 1'b1;
            end
            if (state == FLUSH && x == X_LAST) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`else
    // Error and frame-count tracking not built
`endif

endmodule

// File: tb/tb_medfilt_win_ctrl.sv
// tb/tb_medfilt_win_ctrl.sv - randomized self-checking bench for medfilt_win_ctrl
module tb_medfilt_win_ctrl;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int LAT = 3;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic [1:0]    lb_addr;
    logic          lb_wr_en;
    logic [DW-1:0] lb_wdata;
    logic          col_valid, top_rep, bot_rep, left_rep, right_rep;
    logic          out_valid, out_sof, out_eol, busy;
`ifdef MEDFILT_WIN_CTRL_ERR_EN
    logic          err_sof;
    logic [15:0]   frame_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    int cyc = 0;
    int acc_cnt, wr_cnt, nrdy_cnt, gap_err;
    int cv_cyc[$];
    int cv_flag[$];
    int ov_cyc[$];
    int ov_sof[$];
    int ov_eol[$];

    always #5 clk = ~clk;

    medfilt_win_ctrl #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H),
        .PIPE_LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .lb_addr   (lb_addr),
        .lb_wr_en  (lb_wr_en),
        .lb_wdata  (lb_wdata),
        .col_valid (col_valid),
        .top_rep   (top_rep),
        .bot_rep   (bot_rep),
        .left_rep  (left_rep),
        .right_rep (right_rep),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .busy      (busy)
`ifdef MEDFILT_WIN_CTRL_ERR_EN
        ,
        .err_sof   (err_sof),
        .frame_cnt (frame_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Event log sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (in_valid && in_ready) acc_cnt++;
        if (lb_wr_en) wr_cnt++;
        if (busy && !in_ready) nrdy_cnt++;
        if (col_valid && in_ready && !in_valid) gap_err++;
        if (col_valid) begin
            cv_cyc.push_back(cyc);
            cv_flag.push_back((int'(lb_addr) << 4) | (int'(top_rep) << 3) | (int'(bot_rep) << 2)
                              | (int'(left_rep) << 1) | int'(right_rep));
        end
        if (out_valid) begin
            ov_cyc.push_back(cyc);
            ov_sof.push_back(int'(out_sof));
            ov_eol.push_back(int'(out_eol));
        end
    end

    task automatic clear_logs();
        acc_cnt = 0; wr_cnt = 0; nrdy_cnt = 0; gap_err = 0;
        cv_cyc.delete(); cv_flag.delete();
        ov_cyc.delete(); ov_sof.delete(); ov_eol.delete();
    endtask

    task automatic drive_pix(input bit sof, input bit gappy);
        int  tries = 0;
        bit  done = 0;
        while (!done) begin
            in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            in_sof   = sof & in_valid;
            in_data  = DW'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) done = 1;
            @(posedge clk); #1;
            tries++;
            if (!done && tries > 200) begin
                check("pix_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", 0, 1);
        repeat (LAT + 2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_frame(input bit gappy);
        clear_logs();
        drive_pix(1'b1, gappy);
        repeat (W * H - 1) drive_pix(1'b0, gappy);
        wait_idle();
    endtask

    // Expected frame: one column per pixel position in raster order, latency LAT to the output
    task automatic check_frame();
        check("cv_count", cv_cyc.size(), W * H);
        check("ov_count", ov_cyc.size(), W * H);
        check("wr_count", wr_cnt, W * H + W);
        check("flush_not_ready", nrdy_cnt, W);
        check("gap_col_valid", gap_err, 0);
        for (int i = 0; i < W * H && i < cv_cyc.size(); i++) begin
            int r = i / W;
            int c = i % W;
            int e = (c << 4) | (int'(r == 0) << 3) | (int'(r == H - 1) << 2)
                    | (int'(c == 0) << 1) | int'(c == W - 1);
            check("cv_flags", cv_flag[i], e);
        end
        for (int i = 0; i < ov_cyc.size() && i < cv_cyc.size(); i++) begin
            check("ov_latency", ov_cyc[i] - cv_cyc[i], LAT);
            check("ov_sof", ov_sof[i], int'(i == 0));
            check("ov_eol", ov_eol[i], int'((i % W) == W - 1));
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        clear_logs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_col_valid", col_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_lb_addr", lb_addr, 0);
        @(posedge clk); #1;

        run_frame(1'b0);
        check_frame();

        clear_logs();
        repeat (5) drive_pix(1'b0, 1'b0);
        check("idle_acc", acc_cnt, 5);
        check("idle_wr", wr_cnt, 0);
        check("idle_cv", cv_cyc.size(), 0);
        check("idle_busy", busy, 0);

        for (int k = 0; k < 3; k++) begin
            run_frame(1'b1);
            check_frame();
        end

        clear_logs();
        drive_pix(1'b1, 1'b0);
        repeat (W + 1) drive_pix(1'b0, 1'b0);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_addr", lb_addr, 2);
        pulse_reset();
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_col_valid", col_valid, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_sof", out_sof, 0);
        check("mid_rst_out_eol", out_eol, 0);
        check("mid_rst_lb_wr_en", lb_wr_en, 0);
        check("mid_rst_flags", {top_rep, bot_rep, left_rep, right_rep}, 0);
        check("mid_rst_addr", lb_addr, 0);
        @(posedge clk); #1;
        run_frame(1'b1);
        check_frame();

`ifdef MEDFILT_WIN_CTRL_ERR_EN
        pulse_reset();
        check("err_rst", err_sof, 0);
        check("fcnt_rst", frame_cnt, 0);
        run_frame(1'b0);
        run_frame(1'b1);
        check("fcnt_two", frame_cnt, 2);
        check("err_clean", err_sof, 0);
        clear_logs();
        drive_pix(1'b1, 1'b0);
        repeat (W) drive_pix(1'b0, 1'b0);
        drive_pix(1'b1, 1'b0);
        check("err_set", err_sof, 1);
        repeat (W * H - W - 2) drive_pix(1'b0, 1'b0);
        wait_idle();
        check("err_hold", err_sof, 1);
        check("fcnt_three", frame_cnt, 3);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
